// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter driving the one-hot source selects of the internal data bus mux.
// Bounded tenure (MAX_HOLD) with lock override and an optional idle turnaround cycle.
module bus_source_arbiter #(
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] req,
  input  logic       lock,
  output logic       select_0,
  output logic       select_1,
  output logic       select_2,
  output logic       select_3,
  output logic       select_4,
  output logic       select_5,
  output logic       select_6,
  output logic       select_7,
  output logic       select_8,
  output logic       select_9,
  output logic       bus_busy,
  output logic [3:0] owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD = 4'(MAX_HOLD);
  localparam logic [3:0] NONE = 4'hF;
  localparam logic       TA   = (TURNAROUND != 0);

  state_t     state_q;
  logic [9:0] sel_q;
  logic [3:0] owner_q;
  logic [3:0] ptr_q;
  logic [3:0] cnt_q;
  logic       busy_q;

  logic [3:0] ptr_rel_d;
  logic       owner_req_d;
  logic       others_d;
  logic       release_d;
  logic [4:0] win_ptr_d;
  logic [4:0] win_rel_d;

  // Returns {found, index} of the first requester at or after start, wrapping 9 -> 0.
  function automatic logic [4:0] arbitrate(input logic [9:0] r, input logic [3:0] start);
    logic [4:0] res;
    logic [3:0] idx4;
    int         idx;
    res = {1'b0, NONE};
    for (int k = 9; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= 10) idx = idx - 10;
      idx4 = 4'(idx);
      if (r[idx4]) res = {1'b1, idx4};
    end
    return res;
  endfunction

  always_comb begin
    ptr_rel_d   = (owner_q >= 4'd9) ? 4'd0 : owner_q + 4'd1;
    owner_req_d = |(req & sel_q);
    others_d    = |(req & ~sel_q);
    release_d   = ~owner_req_d | ((cnt_q == HOLD) & ~lock & others_d);
    win_ptr_d   = arbitrate(req, ptr_q);
    win_rel_d   = arbitrate(req, ptr_rel_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      owner_q <= NONE;
      busy_q  <= 1'b0;
      ptr_q   <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_GAP: begin
          if (win_ptr_d[4]) begin
            state_q <= ST_OWN;
            owner_q <= win_ptr_d[3:0];
            sel_q   <= 10'd1 << win_ptr_d[3:0];
            busy_q  <= 1'b1;
            cnt_q   <= 4'd1;
          end else begin
            state_q <= ST_IDLE;
            owner_q <= NONE;
            sel_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_OWN: begin
          if (release_d) begin
            ptr_q <= ptr_rel_d;
            // Back-to-back handover arbitrates from the post-release pointer.
            if (!TA && win_rel_d[4]) begin
              state_q <= ST_OWN;
              owner_q <= win_rel_d[3:0];
              sel_q   <= 10'd1 << win_rel_d[3:0];
              busy_q  <= 1'b1;
              cnt_q   <= 4'd1;
            end else begin
              state_q <= TA ? ST_GAP : ST_IDLE;
              owner_q <= NONE;
              sel_q   <= '0;
              busy_q  <= 1'b0;
            end
          end else if (cnt_q != HOLD) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          owner_q <= NONE;
          sel_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign select_0 = sel_q[0];
  assign select_1 = sel_q[1];
  assign select_2 = sel_q[2];
  assign select_3 = sel_q[3];
  assign select_4 = sel_q[4];
  assign select_5 = sel_q[5];
  assign select_6 = sel_q[6];
  assign select_7 = sel_q[7];
  assign select_8 = sel_q[8];
  assign select_9 = sel_q[9];
  assign bus_busy = busy_q;
  assign owner    = owner_q;

endmodule

// File: doc/bus_source_arbiter.md
# bus_source_arbiter

- Sequences the one-hot source selects of the 8-bit internal data bus multiplexer.
- Accepts up to ten requesters and grants the bus to exactly one at a time, using round-robin priority and a bounded tenure.
- Can insert an optional all-deselected turnaround cycle between owners.
- Sits between the control unit's transfer requests and the bus multiplexer's `select_0`..`select_9` inputs. It guarantees the multiplexer never sees two selects asserted at once.

## Interface
- `MAX_HOLD`, default 4: maximum cycles an owner keeps the bus while another requester waits. Legal range is 1..15.
- `TURNAROUND`, default 1: 1 inserts one idle cycle (all selects low) between owners; 0 allows back-to-back handover.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `req` input, 10 bits: `req[i]` high means source i wants the bus. Level-sensitive, held for the whole transfer.
- `lock` input, 1 bit: while high, suppresses MAX_HOLD preemption of the current owner. Ignored when no owner.
- `select_0`..`select_9` output, 1 bit each: registered one-hot bus source selects, wired directly to the bus multiplexer.
- `bus_busy` output, 1 bit: OR of all selects.
- `owner` output, 4 bits: index of the asserted select; 4'hF when none.

## Operation
- States: IDLE, OWN, GAP. All outputs are registered.
- Internal state:
  - `ptr` (0..9): round-robin start index.
  - `o`: current owner.
  - `cnt`: cycles owned, saturating at MAX_HOLD.
- Arbitration function, used in IDLE, GAP and OWN-release:
  - Pick the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … with wrap 9→0.
  - If none is found, there is no grant.
- IDLE:
  - All selects low.
  - If any `req`: o←winner, cnt←1, state←OWN, so `select_o` rises at the next edge.
  - Otherwise stay in IDLE.
- OWN:
  - `select_o` high; cnt increments, saturating.
  - Release when `req[o]`=0, or when (cnt==MAX_HOLD and `lock`=0 and any `req[j]`=1 with j≠o).
  - On release, `ptr`←(o+1) mod 10.
  - If TURNAROUND=1: state←GAP.
  - If TURNAROUND=0: arbitrate in the same cycle using the new `ptr`. A winner becomes the owner at the next edge (cnt←1); if there is no winner, go to IDLE.
  - Without a release, ownership persists indefinitely, including when `lock`=0 and no one else is waiting.
- GAP:
  - All selects low for exactly one cycle.
  - Arbitrate exactly as in IDLE: a winner leads to OWN, otherwise IDLE.
- Invariants:
  - Never more than one select high.
  - With TURNAROUND=1, two different owners are never in adjacent cycles.
  - `owner` and `bus_busy` are always consistent with the selects.
- Reset (async, `rst_n`=0) forces the following immediately, without waiting for a clock edge:
  - state=IDLE, all selects low, `bus_busy`=0, `owner`=4'hF.
  - `ptr`=0, cnt=0.
- Simultaneous events:
  - A new requester and the owner's `req` drop in the same cycle: release takes precedence, then normal arbitration.
  - Release in the cycle `lock` falls: allowed if cnt has already saturated at MAX_HOLD.

## Timing
- Latency from `req` rising in IDLE to the select high: 1 cycle.
- Owner `req` drop to its select low: 1 cycle.
- Handover gap:
  - TURNAROUND=1: one cycle with all selects low.
  - TURNAROUND=0: the next owner's select rises on the same edge the old select falls.
- `lock` and `req` are sampled every edge; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=10'h3FF, then release at cycle 0. Required: all selects 0, `owner`=F and `bus_busy`=0 during reset. At cycle 1, `select_0` is high (`ptr`=0).
- **Single requester:** `req[3]` held from cycle 0 for 10 cycles, then dropped. Required: `select_3` high cycles 1–10, low from cycle 11, `owner`=3 while high. There is no preemption.
- **Contention with preemption** (MAX_HOLD=4, TURNAROUND=1): `req[2]` and `req[7]` held from cycle 0. Required:
  - `select_2` high cycles 1–4.
  - All selects low at cycle 5.
  - `select_7` high from cycle 6.
  - `ptr` moves to 3 and then to 8.
- **Lock:** same as the contention case, with `lock`=1 during cycles 0–7. Required: `select_2` high cycles 1–8, gap at cycle 9, `select_7` from cycle 10.
- **Wrap and back-to-back** (TURNAROUND=0): owner 9 releases with `req[0]` and `req[5]` pending. Required: `select_9` falls and `select_0` rises on the same edge; there is never a cycle with two selects high.
- **Reset mid-ownership:** drive `rst_n` low mid-cycle while `select_6` is high. Required:
  - `select_6` drops before the next edge.
  - After reset release with `req[6]` and `req[1]` pending, `select_1` is granted (`ptr`=0).
